// File: rtl/sb_xbar_nxm.sv
// Simple-bus NM-master x NS-slave crossbar. Read and write paths each run an
// independent round-robin engine with a single transaction in flight.

module sb_xbar_eng #(
  parameter int              NM      = 2,
  parameter int              NS      = 4,
  parameter int              SB      = 2,
  parameter int              PW      = 32,
  parameter int              RW      = 1,
  parameter logic [RW-1:0]   ERR_RSP = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_valid_i,
  output logic [NM-1:0]    m_ready_o,
  input  logic [NM*PW-1:0] m_pay_i,
  output logic [NM-1:0]    m_rvalid_o,
  input  logic [NM-1:0]    m_rready_i,
  output logic [NM*RW-1:0] m_rpay_o,
  output logic [NS-1:0]    s_valid_o,
  input  logic [NS-1:0]    s_ready_i,
  output logic [NS*PW-1:0] s_pay_o,
  input  logic [NS-1:0]    s_rvalid_i,
  output logic [NS-1:0]    s_rready_o,
  input  logic [NS*RW-1:0] s_rpay_i
);
  localparam int GW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [SB-1:0] sidx_q, sidx_d;
  logic          err_q, err_d;

  logic [GW-1:0] win;
  logic [SB-1:0] win_sidx;
  logic          win_found;
  logic          g_valid, g_rready;
  logic [PW-1:0] g_pay;
  logic          sl_ready, sl_rvalid;
  logic [RW-1:0] sl_rpay;
  logic          legal;
  logic          rsp_valid;
  logic [RW-1:0] rsp_pay;

  // Round-robin search from ptr; the address sits in the top bits of each payload.
  always_comb begin
    win       = '0;
    win_sidx  = '0;
    win_found = 1'b0;
    for (int k = 0; k < NM; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NM) j = j - NM;
      if (!win_found && m_valid_i[j]) begin
        win_found = 1'b1;
        win       = GW'(j);
        win_sidx  = m_pay_i[j*PW + PW-1 -: SB];
      end
    end
  end

  always_comb begin
    g_valid   = 1'b0;
    g_rready  = 1'b0;
    g_pay     = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q == GW'(i)) begin
        g_valid  = m_valid_i[i];
        g_rready = m_rready_i[i];
        g_pay    = m_pay_i[i*PW +: PW];
      end
    end
    sl_ready  = 1'b0;
    sl_rvalid = 1'b0;
    sl_rpay   = '0;
    for (int s = 0; s < NS; s++) begin
      if (sidx_q == SB'(s)) begin
        sl_ready  = s_ready_i[s];
        sl_rvalid = s_rvalid_i[s];
        sl_rpay   = s_rpay_i[s*RW +: RW];
      end
    end
  end

  assign legal = (32'(sidx_q) < 32'(NS));

  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path through the case can infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    sidx_d     = sidx_q;
    err_d      = err_q;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    m_rpay_o   = '0;
    s_valid_o  = '0;
    s_pay_o    = '0;
    s_rready_o = '0;
    rsp_valid  = err_q | sl_rvalid;
    rsp_pay    = err_q ? ERR_RSP : sl_rpay;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = win;
          sidx_d  = win_sidx;
          err_d   = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        for (int s = 0; s < NS; s++) begin
          if (legal && sidx_q == SB'(s)) begin
            s_valid_o[s]         = g_valid;
            s_pay_o[s*PW +: PW]  = g_pay;
          end
        end
        for (int i = 0; i < NM; i++) begin
          if (gnt_q == GW'(i)) m_ready_o[i] = legal ? sl_ready : 1'b1;
        end
        // An unmapped index is acknowledged locally for one cycle and answered with an error.
        if (!legal) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (g_valid && sl_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        for (int i = 0; i < NM; i++) begin
          if (gnt_q == GW'(i)) begin
            m_rvalid_o[i]          = rsp_valid;
            m_rpay_o[i*RW +: RW]   = rsp_pay;
          end
        end
        for (int s = 0; s < NS; s++) begin
          if (!err_q && sidx_q == SB'(s)) s_rready_o[s] = g_rready;
        end
        if (rsp_valid && g_rready) begin
          state_d = IDLE;
          ptr_d   = (gnt_q == GW'(NM-1)) ? '0 : gnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      sidx_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sidx_q  <= sidx_d;
      err_q   <= err_d;
    end
  end

endmodule

module sb_xbar_nxm #(
  parameter int NM = 2,
  parameter int NS = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SB = 2,
  localparam int SW = DW / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    sb_arvalid_m,
  output logic [NM-1:0]    sb_arready_m,
  input  logic [NM*AW-1:0] sb_araddr_m,
  output logic [NM-1:0]    sb_rvalid_m,
  input  logic [NM-1:0]    sb_rready_m,
  output logic [NM*DW-1:0] sb_rdata_m,
  output logic [NM-1:0]    sb_rresp_m,
  input  logic [NM-1:0]    sb_wvalid_m,
  output logic [NM-1:0]    sb_wready_m,
  input  logic [NM*AW-1:0] sb_waddr_m,
  input  logic [NM*DW-1:0] sb_wdata_m,
  input  logic [NM*SW-1:0] sb_wstrb_m,
  output logic [NM-1:0]    sb_bvalid_m,
  input  logic [NM-1:0]    sb_bready_m,
  output logic [NM-1:0]    sb_bresp_m,
  output logic [NS-1:0]    sb_arvalid_s,
  input  logic [NS-1:0]    sb_arready_s,
  output logic [NS*AW-1:0] sb_araddr_s,
  input  logic [NS-1:0]    sb_rvalid_s,
  output logic [NS-1:0]    sb_rready_s,
  input  logic [NS*DW-1:0] sb_rdata_s,
  output logic [NS-1:0]    sb_wvalid_s,
  input  logic [NS-1:0]    sb_wready_s,
  output logic [NS*AW-1:0] sb_waddr_s,
  output logic [NS*DW-1:0] sb_wdata_s,
  output logic [NS*SW-1:0] sb_wstrb_s,
  input  logic [NS-1:0]    sb_bvalid_s,
  output logic [NS-1:0]    sb_bready_s,
  input  logic [NS-1:0]    sb_bresp_s
);
  localparam int WPW = AW + DW + SW;
  localparam int RRW = DW + 1;

  logic [NM*WPW-1:0] w_mpay;
  logic [NS*WPW-1:0] w_spay;
  logic [NS*RRW-1:0] r_srsp;
  logic [NM*RRW-1:0] r_mrsp;

  // Read responses carry {rresp, rdata}; slaves never signal a read error themselves.
  for (genvar s = 0; s < NS; s++) begin : g_slv
    assign r_srsp[s*RRW +: RRW] = {1'b0, sb_rdata_s[s*DW +: DW]};
    assign {sb_waddr_s[s*AW +: AW], sb_wdata_s[s*DW +: DW], sb_wstrb_s[s*SW +: SW]} =
      w_spay[s*WPW +: WPW];
  end

  for (genvar i = 0; i < NM; i++) begin : g_mst
    assign w_mpay[i*WPW +: WPW] =
      {sb_waddr_m[i*AW +: AW], sb_wdata_m[i*DW +: DW], sb_wstrb_m[i*SW +: SW]};
    assign {sb_rresp_m[i], sb_rdata_m[i*DW +: DW]} = r_mrsp[i*RRW +: RRW];
  end

  sb_xbar_eng #(
    .NM(NM), .NS(NS), .SB(SB), .PW(AW), .RW(RRW),
    .ERR_RSP({1'b1, {DW{1'b0}}})
  ) u_rd (
    .clk       (clk),
    .rst       (rst),
    .m_valid_i (sb_arvalid_m),
    .m_ready_o (sb_arready_m),
    .m_pay_i   (sb_araddr_m),
    .m_rvalid_o(sb_rvalid_m),
    .m_rready_i(sb_rready_m),
    .m_rpay_o  (r_mrsp),
    .s_valid_o (sb_arvalid_s),
    .s_ready_i (sb_arready_s),
    .s_pay_o   (sb_araddr_s),
    .s_rvalid_i(sb_rvalid_s),
    .s_rready_o(sb_rready_s),
    .s_rpay_i  (r_srsp)
  );

  sb_xbar_eng #(
    .NM(NM), .NS(NS), .SB(SB), .PW(WPW), .RW(1),
    .ERR_RSP(1'b1)
  ) u_wr (
    .clk       (clk),
    .rst       (rst),
    .m_valid_i (sb_wvalid_m),
    .m_ready_o (sb_wready_m),
    .m_pay_i   (w_mpay),
    .m_rvalid_o(sb_bvalid_m),
    .m_rready_i(sb_bready_m),
    .m_rpay_o  (sb_bresp_m),
    .s_valid_o (sb_wvalid_s),
    .s_ready_i (sb_wready_s),
    .s_pay_o   (w_spay),
    .s_rvalid_i(sb_bvalid_s),
    .s_rready_o(sb_bready_s),
    .s_rpay_i  (sb_bresp_s)
  );

endmodule

// File: tb/tb_sb_xbar_nxm.sv
// Directed bench for sb_xbar_nxm with 2 masters and 3 slaves, so index 3 is unmapped.

module tb_sb_xbar_nxm;
  localparam int NM = 2;
  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SB = 2;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NM-1:0]    sb_arvalid_m, sb_arready_m, sb_rvalid_m, sb_rready_m, sb_rresp_m;
  logic [NM*AW-1:0] sb_araddr_m, sb_waddr_m;
  logic [NM*DW-1:0] sb_rdata_m, sb_wdata_m;
  logic [NM-1:0]    sb_wvalid_m, sb_wready_m, sb_bvalid_m, sb_bready_m, sb_bresp_m;
  logic [NM*SW-1:0] sb_wstrb_m;
  logic [NS-1:0]    sb_arvalid_s, sb_arready_s, sb_rvalid_s, sb_rready_s;
  logic [NS*AW-1:0] sb_araddr_s, sb_waddr_s;
  logic [NS*DW-1:0] sb_rdata_s, sb_wdata_s;
  logic [NS-1:0]    sb_wvalid_s, sb_wready_s, sb_bvalid_s, sb_bready_s, sb_bresp_s;
  logic [NS*SW-1:0] sb_wstrb_s;

  int total = 0;
  int bad   = 0;

  sb_xbar_nxm #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SB(SB)) dut (
    .clk(clk), .rst(rst),
    .sb_arvalid_m(sb_arvalid_m), .sb_arready_m(sb_arready_m), .sb_araddr_m(sb_araddr_m),
    .sb_rvalid_m(sb_rvalid_m), .sb_rready_m(sb_rready_m), .sb_rdata_m(sb_rdata_m),
    .sb_rresp_m(sb_rresp_m),
    .sb_wvalid_m(sb_wvalid_m), .sb_wready_m(sb_wready_m), .sb_waddr_m(sb_waddr_m),
    .sb_wdata_m(sb_wdata_m), .sb_wstrb_m(sb_wstrb_m),
    .sb_bvalid_m(sb_bvalid_m), .sb_bready_m(sb_bready_m), .sb_bresp_m(sb_bresp_m),
    .sb_arvalid_s(sb_arvalid_s), .sb_arready_s(sb_arready_s), .sb_araddr_s(sb_araddr_s),
    .sb_rvalid_s(sb_rvalid_s), .sb_rready_s(sb_rready_s), .sb_rdata_s(sb_rdata_s),
    .sb_wvalid_s(sb_wvalid_s), .sb_wready_s(sb_wready_s), .sb_waddr_s(sb_waddr_s),
    .sb_wdata_s(sb_wdata_s), .sb_wstrb_s(sb_wstrb_s),
    .sb_bvalid_s(sb_bvalid_s), .sb_bready_s(sb_bready_s), .sb_bresp_s(sb_bresp_s)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    sb_arvalid_m = '0; sb_araddr_m = '0; sb_rready_m = '0;
    sb_wvalid_m  = '0; sb_waddr_m  = '0; sb_wdata_m  = '0; sb_wstrb_m = '0;
    sb_bready_m  = '0;
    sb_arready_s = '1; sb_rvalid_s = '0; sb_rdata_s  = '0;
    sb_wready_s  = '1; sb_bvalid_s = '0; sb_bresp_s  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [NM-1:0] exp_g;
    int n;

    // Reset state, with requests already pending
    clear_inputs();
    sb_arvalid_m = 2'b11;
    sb_wvalid_m  = 2'b11;
    repeat (2) @(negedge clk);
    check("rst_outs", {sb_arready_m, sb_rvalid_m, sb_wready_m, sb_bvalid_m,
                       sb_arvalid_s, sb_rready_s, sb_wvalid_s, sb_bready_s}, 0);
    clear_inputs();
    rst = 1'b0;

    // m0 reads s1, slave answers two cycles after the address handshake
    sb_arvalid_m     = 2'b01;
    sb_araddr_m[31:0] = 32'h4000_0010;
    sb_rready_m      = 2'b01;
    #1;
    check("rd_idle_ready", sb_arready_m, 0);
    check("rd_idle_svalid", sb_arvalid_s, 0);
    @(negedge clk);
    check("rd_svalid", sb_arvalid_s, 3'b010);
    check("rd_saddr", sb_araddr_s[32 +: 32], 32'h4000_0010);
    check("rd_mready", sb_arready_m, 2'b01);
    @(negedge clk);
    sb_arvalid_m = '0;
    #1;
    check("rd_wait_rvalid", sb_rvalid_m, 0);
    check("rd_rready_s", sb_rready_s, 3'b010);
    @(negedge clk);
    sb_rvalid_s[1]         = 1'b1;
    sb_rdata_s[32 +: 32]   = 32'hA5A5_A5A5;
    #1;
    check("rd_rvalid", sb_rvalid_m, 2'b01);
    check("rd_rdata", sb_rdata_m[31:0], 32'hA5A5_A5A5);
    check("rd_rresp", sb_rresp_m, 0);
    check("rd_rdata_other", sb_rdata_m[63:32], 0);
    @(negedge clk);
    sb_rvalid_s = '0;
    #1;
    check("rd_done", sb_rvalid_m, 0);

    // Both masters hammer s0: grants alternate starting from m0 after reset
    do_reset();
    sb_arvalid_m = 2'b11;
    sb_araddr_m  = {32'h0000_0004, 32'h0000_0000};
    sb_rvalid_s  = 3'b001;
    sb_rdata_s[31:0] = 32'h11;
    sb_rready_m  = 2'b11;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk);
      if (sb_arready_m != 0) begin
        exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
        check($sformatf("rr_grant%0d", n), sb_arready_m, exp_g);
        n++;
      end
    end
    check("rr_count", n, 4);

    // m1 writes to unmapped index 3: local wready, then error response
    do_reset();
    sb_wvalid_m          = 2'b10;
    sb_waddr_m[63:32]    = 32'hC000_0000;
    sb_wdata_m[63:32]    = 32'h0000_1234;
    sb_wstrb_m[7:4]      = 4'hF;
    #1;
    check("err_idle_wready", sb_wready_m, 0);
    @(negedge clk);
    check("err_no_svalid", sb_wvalid_s, 0);
    check("err_wready", sb_wready_m, 2'b10);
    @(negedge clk);
    sb_wvalid_m = '0;
    #1;
    check("err_wready_once", sb_wready_m, 0);
    check("err_bvalid", sb_bvalid_m, 2'b10);
    check("err_bresp", sb_bresp_m, 2'b10);
    @(negedge clk);
    check("err_bvalid_hold", sb_bvalid_m, 2'b10);
    sb_bready_m = 2'b10;
    #1;
    check("err_no_bready_s", sb_bready_s, 0);
    @(negedge clk);
    sb_bready_m = '0;
    #1;
    check("err_done", sb_bvalid_m, 0);

    // Concurrent read (m0) and write (m1) to s2
    do_reset();
    sb_arvalid_m         = 2'b01;
    sb_araddr_m[31:0]    = 32'h8000_0000;
    sb_wvalid_m          = 2'b10;
    sb_waddr_m[63:32]    = 32'h8000_0020;
    sb_wdata_m[63:32]    = 32'hDEAD_BEEF;
    sb_wstrb_m[7:4]      = 4'b0011;
    sb_rready_m          = 2'b01;
    sb_bready_m          = 2'b10;
    @(negedge clk);
    check("cc_arvalid_s", sb_arvalid_s, 3'b100);
    check("cc_wvalid_s", sb_wvalid_s, 3'b100);
    check("cc_araddr_s", sb_araddr_s[64 +: 32], 32'h8000_0000);
    check("cc_waddr_s", sb_waddr_s[64 +: 32], 32'h8000_0020);
    check("cc_wdata_s", sb_wdata_s[64 +: 32], 32'hDEAD_BEEF);
    check("cc_wstrb_s", sb_wstrb_s[8 +: 4], 4'b0011);
    check("cc_ready_m", {sb_arready_m, sb_wready_m}, 4'b0110);
    @(negedge clk);
    sb_arvalid_m = '0;
    sb_wvalid_m  = '0;
    sb_rvalid_s  = 3'b100;
    sb_rdata_s[64 +: 32] = 32'h55AA_0FF0;
    sb_bvalid_s  = 3'b100;
    #1;
    check("cc_rvalid", sb_rvalid_m, 2'b01);
    check("cc_rdata", sb_rdata_m[31:0], 32'h55AA_0FF0);
    check("cc_bvalid", sb_bvalid_m, 2'b10);
    check("cc_bresp", sb_bresp_m, 0);
    check("cc_rsp_ready_s", {sb_rready_s, sb_bready_s}, 6'b100_100);
    @(negedge clk);
    sb_rvalid_s = '0;
    sb_bvalid_s = '0;
    #1;
    check("cc_done", {sb_rvalid_m, sb_bvalid_m}, 0);

    // Slave holds rvalid while the master is not ready
    do_reset();
    sb_arvalid_m      = 2'b01;
    sb_araddr_m[31:0] = 32'h4000_0000;
    @(negedge clk);
    @(negedge clk);
    sb_arvalid_m = '0;
    sb_rvalid_s  = 3'b010;
    sb_rdata_s[32 +: 32] = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold_rvalid%0d", c), sb_rvalid_m, 2'b01);
      check($sformatf("hold_rdata%0d", c), sb_rdata_m[31:0], 32'hCAFE_F00D);
      @(negedge clk);
    end
    sb_rready_m = 2'b01;
    #1;
    check("hold_rready_s", sb_rready_s, 3'b010);
    @(negedge clk);
    sb_rvalid_s = '0;
    sb_rready_m = '0;
    #1;
    check("hold_done", sb_rvalid_m, 0);

    // Reset during a pending response, then m1 is granted one cycle after asking
    do_reset();
    sb_arvalid_m = 2'b01;
    @(negedge clk);
    @(negedge clk);
    sb_arvalid_m = '0;
    sb_rvalid_s  = 3'b001;
    #1;
    check("rr_pre_rvalid", sb_rvalid_m, 2'b01);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {sb_rvalid_m, sb_rready_s, sb_arready_m}, 0);
    @(negedge clk);
    rst = 1'b0;
    sb_arvalid_m         = 2'b10;
    sb_araddr_m[63:32]   = 32'h4000_0000;
    #1;
    check("rst_post_idle", {sb_arready_m, sb_rvalid_m}, 0);
    @(negedge clk);
    check("rst_post_grant", sb_arready_m, 2'b10);
    check("rst_post_svalid", sb_arvalid_s, 3'b010);
    check("rst_post_rvalid", sb_rvalid_m, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sb_xbar_nxm.md
SB_XBAR_NXM -- requirements
Module: sb_xbar_nxm

Interface
REQ-001 Parameter NM, default 2: number of masters, range 1..8.
REQ-002 Parameter NS, default 4: number of slaves, range 1..2**SB.
REQ-003 Parameter AW, default 32: address width.
REQ-004 Parameter DW, default 32: data width, a multiple of 8; strobe width SW = DW/8.
REQ-005 Parameter SB, default 2: decode bits; slave index = addr[AW-1 -: SB].
REQ-006 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-007 Port clk, input, 1 bit: rising-edge clock.
REQ-008 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-009 Master-side ports, with one bit or slice per master i (slice [i*W +: W]):
- sb_arvalid_m in NM; sb_arready_m out NM; sb_araddr_m in NM*AW
- sb_rvalid_m out NM; sb_rready_m in NM; sb_rdata_m out NM*DW; sb_rresp_m out NM
- sb_wvalid_m in NM; sb_wready_m out NM; sb_waddr_m in NM*AW; sb_wdata_m in NM*DW; sb_wstrb_m in NM*SW
- sb_bvalid_m out NM; sb_bready_m in NM; sb_bresp_m out NM
REQ-010 Slave-side ports use the same signals with suffix _s, width NS per slave, and directions mirrored.
- The slave side has no rresp port.
- sb_bresp_s is an input of NS bits.

Function
REQ-011 Read and write paths SHALL each contain an independent, identical engine with states IDLE, ADDR and RESP; each engine has at most one outstanding transaction.
REQ-012 IDLE: if any request valid (arvalid for read, wvalid for write), the engine SHALL select a winner round-robin starting at pointer ptr, register grant gnt and decoded index sidx, and go to ADDR on the next edge.
- Arbitration latency is 1 cycle.
- No ready is asserted in IDLE.
REQ-013 ADDR, index legal (sidx<NS):
- Forward the granted master's valid, addr, data and strb to slave sidx only.
- All other slaves' valid SHALL be 0.
- Return the slave's ready to master gnt only.
- On the valid&ready handshake, go to RESP.
REQ-014 ADDR, index illegal (sidx>=NS): assert ready to master gnt for exactly one cycle without touching any slave, then go to RESP with err=1.
REQ-015 RESP, normal:
- Route slave sidx's rvalid/rdata (or bvalid/bresp) to master gnt.
- Route master gnt's rready/bready to slave sidx.
- sb_rresp_m[gnt] = 0.
REQ-016 RESP, err=1: drive rvalid=1, rdata=0, rresp=1 (write path: bvalid=1, bresp=1) to master gnt until that master is ready.
REQ-017 On the response handshake, the engine SHALL go to IDLE and set ptr = (gnt+1) mod NM.
REQ-018 A master that drops valid while in ADDR is a protocol violation; the engine SHALL keep forwarding the (deasserted) request and SHALL NOT re-arbitrate.
REQ-019 All master-side outputs for non-granted masters SHALL be 0; rdata and bresp outputs for non-granted masters SHALL be 0.
REQ-020 Simultaneous read and write to the same slave SHALL proceed concurrently on the independent channels; ordering between them is not guaranteed.
REQ-021 NM=1 SHALL degenerate to fixed grant 0 with the same 1-cycle IDLE latency.
REQ-022 Forwarded address, data and strobe SHALL be combinational from the granted master; there is no data buffering.

Reset
REQ-023 While rst=1, both engines SHALL be in IDLE with ptr=0, gnt=0, sidx=0 and err=0, and all valid and ready outputs SHALL be 0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction immediately; after release, arbitration restarts from master 0.

Verification
REQ-025 NM=2, NS=4: m0 reads 0x4000_0010 while s1 returns 0xA5A5_A5A5 after 2 cycles -> only sb_arvalid_s[1] asserts; m0 receives rdata 0xA5A5_A5A5 with rresp=0; total latency is 1 + slave latency.
REQ-026 m0 and m1 hold arvalid continuously to s0 -> grants alternate m0, m1, m0, m1; no master is granted twice consecutively.
REQ-027 NS=3: m1 writes 0xC000_0000 with wdata 0x1234 -> no slave wvalid; m1 gets wready for 1 cycle, then bvalid with bresp=1.
REQ-028 m0 reads s2 while m1 writes s2 in the same cycle -> both complete; write data 0xDEAD_BEEF with strb 4'b0011 arrives unchanged at s2.
REQ-029 rst pulsed while read is in RESP with slave rvalid=1 -> no sb_rvalid_m asserts after the edge; the next request from m1 is granted 1 cycle after it is issued.
REQ-030 Slave holds rvalid for 3 cycles with master rready=0 -> rdata is held stable, and the engine does not return to IDLE until rready=1.
